// File: rtl/cu_command_responder.sv
// -----------------------------------------------------------------------------
// cu_command_responder
//
// Memory-side responder for the compute-unit command/response protocol.
// Commands (one 128-byte line each, two 512-bit halves) are queued in a
// command FIFO and serviced strictly in order against an internal line memory.
// Reads return two data halves and then a read response. Writes return a
// write response. All outputs are registered, and every valid is a one-cycle
// pulse.
//
// Ports
//   clock                 single clock, rising edge
//   rstn                  synchronous reset, ACTIVE-HIGH (legacy port name)
//   enabled_in            gates command acceptance and FIFO pops
//   command_valid/type/address/tag/data_0_in/data_1_in
//                         incoming command (type 00 read, 01 write, 1x invalid)
//   command_buffer_full   registered, FIFO occupancy >= FIFO_DEPTH-2
//   read_data_0/1_out     {valid, tag[7:0], data[511:0]}
//   read/write_response_out {valid, tag[7:0], code[1:0]}
//                         code: 00 DONE, 01 AERROR, 10 FAILED
//   read/write_done_count 32-bit wrapping counts of DONE responses
//   overflow_error        sticky, set when a command is dropped on a full FIFO
// -----------------------------------------------------------------------------
module cu_command_responder #(
    parameter int MEM_LINES  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clock,
    input  logic         rstn,
    input  logic         enabled_in,
    input  logic         command_valid,
    input  logic [1:0]   command_type,
    input  logic [63:0]  command_address,
    input  logic [7:0]   command_tag,
    input  logic [511:0] command_data_0_in,
    input  logic [511:0] command_data_1_in,
    output logic         command_buffer_full,
    output logic [520:0] read_data_0_out,
    output logic [520:0] read_data_1_out,
    output logic [10:0]  read_response_out,
    output logic [10:0]  write_response_out,
    output logic [31:0]  read_done_count,
    output logic [31:0]  write_done_count,
    output logic         overflow_error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(MEM_LINES);

    localparam logic [1:0] TYPE_READ  = 2'b00;
    localparam logic [1:0] TYPE_WRITE = 2'b01;

    localparam logic [1:0] RSP_DONE   = 2'b00;
    localparam logic [1:0] RSP_AERROR = 2'b01;
    localparam logic [1:0] RSP_FAILED = 2'b10;

    typedef struct packed {
        logic [1:0]   ctype;
        logic [63:0]  addr;
        logic [7:0]   tag;
        logic [511:0] data_0;
        logic [511:0] data_1;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        READ_H0,
        READ_H1,
        READ_RSP,
        WRITE_RSP,
        ERR_RSP
    } state_t;

    // Storage arrays
    cmd_t         fifo_mem [FIFO_DEPTH];
    logic [1023:0] line_mem [MEM_LINES];   // {half 1, half 0}

    // Registered state
    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic [511:0]      line_hi_q, line_hi_d;
    logic [520:0]      read_data_0_q, read_data_0_d;
    logic [520:0]      read_data_1_q, read_data_1_d;
    logic [10:0]       read_response_q, read_response_d;
    logic [10:0]       write_response_q, write_response_d;
    logic [31:0]       read_done_count_q, read_done_count_d;
    logic [31:0]       write_done_count_q, write_done_count_d;

    // FIFO control
    logic fifo_empty;
    logic fifo_full;
    logic fifo_pop;
    logic cmd_offered;
    logic fifo_push;
    logic cmd_dropped;

    // Decode of the command currently in service
    logic             cmd_misaligned;
    logic             cmd_out_of_range;
    logic [IDX_W-1:0] line_idx;
    logic [1023:0]    mem_line;
    logic             mem_we;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_pop    = (state_q == IDLE) && !fifo_empty && enabled_in;
    assign cmd_offered = command_valid && enabled_in;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign fifo_push   = cmd_offered && (!fifo_full || fifo_pop);
    assign cmd_dropped = cmd_offered && fifo_full && !fifo_pop;

    // The range check covers every upper address bit so high lines never alias.
    assign cmd_misaligned   = (cmd_q.addr[6:0] != 7'd0);
    assign cmd_out_of_range = (cmd_q.addr[63:7] >= 57'(MEM_LINES));
    assign line_idx         = cmd_q.addr[7 +: IDX_W];
    assign mem_line         = line_mem[line_idx];
    assign mem_we           = (state_q == FETCH) && (cmd_q.ctype == TYPE_WRITE)
                              && !cmd_misaligned && !cmd_out_of_range;

    always_comb begin
        // NOTE: every signal gets a default here so no path infers a latch.
        state_d            = state_q;
        cmd_d              = cmd_q;
        line_hi_d          = line_hi_q;
        read_done_count_d  = read_done_count_q;
        write_done_count_d = write_done_count_q;
        // Output channels are pulses: idle at zero unless a state drives them.
        read_data_0_d      = '0;
        read_data_1_d      = '0;
        read_response_d    = '0;
        write_response_d   = '0;

        wr_ptr_d   = fifo_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = fifo_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        full_d     = (count_d >= CNT_W'(FIFO_DEPTH - 2));
        overflow_d = overflow_q | cmd_dropped;

        case (state_q)
            IDLE: begin
                if (fifo_pop) begin
                    cmd_d   = fifo_mem[rd_ptr_q];
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (cmd_q.ctype[1]) begin
                    read_response_d = {1'b1, cmd_q.tag, RSP_FAILED};
                    state_d         = ERR_RSP;
                end else if (cmd_misaligned || cmd_out_of_range) begin
                    if (cmd_q.ctype == TYPE_WRITE) begin
                        write_response_d = {1'b1, cmd_q.tag, RSP_AERROR};
                    end else begin
                        read_response_d  = {1'b1, cmd_q.tag, RSP_AERROR};
                    end
                    state_d = ERR_RSP;
                end else if (cmd_q.ctype == TYPE_READ) begin
                    // Half 0 goes straight out; half 1 is held for the next cycle.
                    read_data_0_d = {1'b1, cmd_q.tag, mem_line[511:0]};
                    line_hi_d     = mem_line[1023:512];
                    state_d       = READ_H0;
                end else begin
                    write_response_d   = {1'b1, cmd_q.tag, RSP_DONE};
                    write_done_count_d = write_done_count_q + 32'd1;
                    state_d            = WRITE_RSP;
                end
            end
            READ_H0: begin
                read_data_1_d = {1'b1, cmd_q.tag, line_hi_q};
                state_d       = READ_H1;
            end
            READ_H1: begin
                read_response_d   = {1'b1, cmd_q.tag, RSP_DONE};
                read_done_count_d = read_done_count_q + 32'd1;
                state_d           = READ_RSP;
            end
            READ_RSP, WRITE_RSP, ERR_RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: storage arrays carry no reset; validity is tracked by pointers/count.
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= '{ctype:  command_type,
                                    addr:   command_address,
                                    tag:    command_tag,
                                    data_0: command_data_0_in,
                                    data_1: command_data_1_in};
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            line_mem[line_idx] <= {cmd_q.data_1, cmd_q.data_0};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (rstn) begin
            state_q            <= IDLE;
            cmd_q              <= '0;
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            count_q            <= '0;
            full_q             <= 1'b0;
            overflow_q         <= 1'b0;
            line_hi_q          <= '0;
            read_data_0_q      <= '0;
            read_data_1_q      <= '0;
            read_response_q    <= '0;
            write_response_q   <= '0;
            read_done_count_q  <= '0;
            write_done_count_q <= '0;
        end else begin
            state_q            <= state_d;
            cmd_q              <= cmd_d;
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            full_q             <= full_d;
            overflow_q         <= overflow_d;
            line_hi_q          <= line_hi_d;
            read_data_0_q      <= read_data_0_d;
            read_data_1_q      <= read_data_1_d;
            read_response_q    <= read_response_d;
            write_response_q   <= write_response_d;
            read_done_count_q  <= read_done_count_d;
            write_done_count_q <= write_done_count_d;
        end
    end

    assign command_buffer_full = full_q;
    assign overflow_error      = overflow_q;
    assign read_data_0_out     = read_data_0_q;
    assign read_data_1_out     = read_data_1_q;
    assign read_response_out   = read_response_q;
    assign write_response_out  = write_response_q;
    assign read_done_count     = read_done_count_q;
    assign write_done_count    = write_done_count_q;

endmodule

// File: tb/tb_cu_command_responder.sv
// -----------------------------------------------------------------------------
// tb_cu_command_responder
//
// Directed bench for cu_command_responder: a table of single-command vectors
// with cycle-exact expected outputs, followed by hand-written sequences for
// ignore-while-disabled, FIFO overflow, counter wrap, enable falling
// mid-command and reset mid-command.
// -----------------------------------------------------------------------------
module tb_cu_command_responder;

    localparam int MEM_LINES  = 64;
    localparam int FIFO_DEPTH = 8;

    localparam logic [1:0] T_RD  = 2'b00;
    localparam logic [1:0] T_WR  = 2'b01;
    localparam logic [1:0] T_I10 = 2'b10;
    localparam logic [1:0] T_I11 = 2'b11;

    localparam logic [1:0] C_DONE   = 2'b00;
    localparam logic [1:0] C_AERROR = 2'b01;
    localparam logic [1:0] C_FAILED = 2'b10;

    localparam logic [511:0] PAT_A = {128{4'hA}};
    localparam logic [511:0] PAT_B = {128{4'hB}};
    localparam logic [511:0] PAT_C = {16{32'h0123_4567}};
    localparam logic [511:0] PAT_D = {16{32'h89AB_CDEF}};
    localparam logic [511:0] PAT_E = {64{8'h5E}};
    localparam logic [511:0] PAT_F = {64{8'hF1}};

    typedef enum logic [1:0] {K_READ_OK, K_WRITE_OK, K_ERR_RD, K_ERR_WR} kind_e;

    typedef struct {
        logic [1:0]   ctype;
        logic [63:0]  addr;
        logic [7:0]   tag;
        logic [511:0] d0;
        logic [511:0] d1;
        kind_e        kind;
        logic [1:0]   code;
        logic [511:0] e0;
        logic [511:0] e1;
    } vec_t;

    logic         clock;
    logic         rstn;
    logic         enabled_in;
    logic         command_valid;
    logic [1:0]   command_type;
    logic [63:0]  command_address;
    logic [7:0]   command_tag;
    logic [511:0] command_data_0_in;
    logic [511:0] command_data_1_in;
    logic         command_buffer_full;
    logic [520:0] read_data_0_out;
    logic [520:0] read_data_1_out;
    logic [10:0]  read_response_out;
    logic [10:0]  write_response_out;
    logic [31:0]  read_done_count;
    logic [31:0]  write_done_count;
    logic         overflow_error;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_rd_cnt = 32'd0;
    logic [31:0] exp_wr_cnt = 32'd0;

    vec_t vecs [11];

    cu_command_responder #(
        .MEM_LINES (MEM_LINES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock              (clock),
        .rstn               (rstn),
        .enabled_in         (enabled_in),
        .command_valid      (command_valid),
        .command_type       (command_type),
        .command_address    (command_address),
        .command_tag        (command_tag),
        .command_data_0_in  (command_data_0_in),
        .command_data_1_in  (command_data_1_in),
        .command_buffer_full(command_buffer_full),
        .read_data_0_out    (read_data_0_out),
        .read_data_1_out    (read_data_1_out),
        .read_response_out  (read_response_out),
        .write_response_out (write_response_out),
        .read_done_count    (read_done_count),
        .write_done_count   (write_done_count),
        .overflow_error     (overflow_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [520:0] act, input logic [520:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] t, input logic [63:0] a, input logic [7:0] g,
                             input logic [511:0] d0, input logic [511:0] d1);
        command_valid     = 1'b1;
        command_type      = t;
        command_address   = a;
        command_tag       = g;
        command_data_0_in = d0;
        command_data_1_in = d1;
    endtask

    task automatic idle_cmd();
        command_valid     = 1'b0;
        command_type      = 2'b00;
        command_address   = 64'd0;
        command_tag       = 8'd0;
        command_data_0_in = '0;
        command_data_1_in = '0;
    endtask

    task automatic check_counts(input string name);
        check({name, " read_done_count"},  521'(read_done_count),  521'(exp_rd_cnt));
        check({name, " write_done_count"}, 521'(write_done_count), 521'(exp_wr_cnt));
    endtask

    // Issues one command into an empty, idle responder and checks every output
    // channel on cycles 1..7 after the accept cycle.
    task automatic run_vec(input vec_t v, input string name);
        logic [520:0] e_rd0, e_rd1;
        logic [10:0]  e_rr, e_wr;
        drive_cmd(v.ctype, v.addr, v.tag, v.d0, v.d1);
        step();
        idle_cmd();
        for (int c = 1; c <= 7; c++) begin
            e_rd0 = '0;
            e_rd1 = '0;
            e_rr  = '0;
            e_wr  = '0;
            case (v.kind)
                K_READ_OK: begin
                    if (c == 3) e_rd0 = {1'b1, v.tag, v.e0};
                    if (c == 4) e_rd1 = {1'b1, v.tag, v.e1};
                    if (c == 5) e_rr  = {1'b1, v.tag, C_DONE};
                end
                K_WRITE_OK: if (c == 3) e_wr = {1'b1, v.tag, C_DONE};
                K_ERR_RD:   if (c == 3) e_rr = {1'b1, v.tag, v.code};
                K_ERR_WR:   if (c == 3) e_wr = {1'b1, v.tag, v.code};
                default: ;
            endcase
            check($sformatf("%s c%0d read_data_0", name, c), read_data_0_out, e_rd0);
            check($sformatf("%s c%0d read_data_1", name, c), read_data_1_out, e_rd1);
            check($sformatf("%s c%0d read_response", name, c), 521'(read_response_out), 521'(e_rr));
            check($sformatf("%s c%0d write_response", name, c), 521'(write_response_out), 521'(e_wr));
            step();
        end
        if (v.kind == K_READ_OK)  exp_rd_cnt = exp_rd_cnt + 32'd1;
        if (v.kind == K_WRITE_OK) exp_wr_cnt = exp_wr_cnt + 32'd1;
        check_counts(name);
    endtask

    initial begin
        vec_t v;
        int   got;
        bit   seen;

        rstn       = 1'b1;
        enabled_in = 1'b0;
        idle_cmd();

        vecs[0]  = '{T_WR,  64'h80,  8'h11, PAT_A, PAT_B, K_WRITE_OK, C_DONE,   '0,    '0};
        vecs[1]  = '{T_RD,  64'h80,  8'h22, '0,    '0,    K_READ_OK,  C_DONE,   PAT_A, PAT_B};
        vecs[2]  = '{T_RD,  64'h81,  8'h23, '0,    '0,    K_ERR_RD,   C_AERROR, '0,    '0};
        vecs[3]  = '{T_RD,  64'h2000, 8'h24, '0,   '0,    K_ERR_RD,   C_AERROR, '0,    '0};
        vecs[4]  = '{T_I11, 64'h80,  8'h33, '0,    '0,    K_ERR_RD,   C_FAILED, '0,    '0};
        vecs[5]  = '{T_I10, 64'h80,  8'h34, '0,    '0,    K_ERR_RD,   C_FAILED, '0,    '0};
        vecs[6]  = '{T_WR,  64'h1F80, 8'h35, PAT_C, PAT_D, K_WRITE_OK, C_DONE,  '0,    '0};
        vecs[7]  = '{T_RD,  64'h1F80, 8'h36, '0,   '0,    K_READ_OK,  C_DONE,   PAT_C, PAT_D};
        vecs[8]  = '{T_WR,  64'h81,  8'h37, PAT_E, PAT_E, K_ERR_WR,   C_AERROR, '0,    '0};
        vecs[9]  = '{T_WR,  64'h8000_0000_0000_0080, 8'h38, PAT_F, PAT_F, K_ERR_WR, C_AERROR, '0, '0};
        vecs[10] = '{T_RD,  64'h80,  8'h39, '0,    '0,    K_READ_OK,  C_DONE,   PAT_A, PAT_B};

        // Reset values
        step();
        step();
        rstn = 1'b0;
        check("reset read_data_0", read_data_0_out, '0);
        check("reset read_data_1", read_data_1_out, '0);
        check("reset read_response", 521'(read_response_out), '0);
        check("reset write_response", 521'(write_response_out), '0);
        check("reset overflow_error", 521'(overflow_error), '0);
        check("reset command_buffer_full", 521'(command_buffer_full), '0);
        check_counts("reset");
        enabled_in = 1'b1;
        step();

        // Single-command vector table
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        check("table overflow_error", 521'(overflow_error), '0);
        check("table command_buffer_full", 521'(command_buffer_full), '0);

        // Commands offered while disabled are ignored and are not an overflow
        enabled_in = 1'b0;
        drive_cmd(T_RD, 64'h80, 8'h5A, '0, '0);
        for (int c = 0; c < 3; c++) step();
        idle_cmd();
        enabled_in = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (read_response_out[10] || read_data_0_out[520]) seen = 1'b1;
            step();
        end
        check("disabled ignored response", 521'(seen), '0);
        check("disabled overflow_error", 521'(overflow_error), '0);
        check_counts("disabled");

        // Overflow: pops held off, ten reads offered to an 8-entry FIFO
        force dut.fifo_pop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_cmd(T_RD, 64'h80, 8'(8'h40 + i), '0, '0);
            step();
            check($sformatf("ovf full after accept %0d", i + 1),
                  521'(command_buffer_full), 521'((i + 1) >= (FIFO_DEPTH - 2)));
        end
        idle_cmd();
        check("ovf overflow_error set", 521'(overflow_error), 521'(1));
        step();
        release dut.fifo_pop;
        got = 0;
        for (int c = 0; c < 80; c++) begin
            if (read_data_0_out[520]) begin
                check($sformatf("ovf rd0 %0d", got), read_data_0_out,
                      {1'b1, 8'(8'h40 + got), PAT_A});
            end
            if (read_response_out[10]) begin
                check($sformatf("ovf rsp %0d", got), 521'(read_response_out),
                      521'({1'b1, 8'(8'h40 + got), C_DONE}));
                got++;
            end
            step();
        end
        check("ovf response count", 521'(got), 521'(8));
        check("ovf overflow_error sticky", 521'(overflow_error), 521'(1));
        check("ovf full after drain", 521'(command_buffer_full), '0);
        exp_rd_cnt = exp_rd_cnt + 32'd8;
        check_counts("ovf");

        // Write counter wraps from all-ones to zero
        force dut.write_done_count_q = 32'hFFFF_FFFF;
        step();
        release dut.write_done_count_q;
        exp_wr_cnt = 32'hFFFF_FFFF;
        check("wrap preload", 521'(write_done_count), 521'(exp_wr_cnt));
        v = '{T_WR, 64'h180, 8'h70, PAT_D, PAT_C, K_WRITE_OK, C_DONE, '0, '0};
        run_vec(v, "wrap");
        check("wrap value zero", 521'(write_done_count), '0);

        // Enable falls with a read in flight and a write queued
        drive_cmd(T_RD, 64'h180, 8'h60, '0, '0);
        step();
        drive_cmd(T_WR, 64'h100, 8'h61, PAT_E, PAT_F);
        step();
        idle_cmd();
        enabled_in = 1'b0;
        for (int c = 2; c <= 14; c++) begin
            check($sformatf("enfall c%0d read_response", c), 521'(read_response_out),
                  (c == 5) ? 521'({1'b1, 8'h60, C_DONE}) : 521'(0));
            check($sformatf("enfall c%0d write_response", c), 521'(write_response_out), '0);
            if (c == 3) check("enfall rd0", read_data_0_out, {1'b1, 8'h60, PAT_D});
            step();
        end
        exp_rd_cnt = exp_rd_cnt + 32'd1;
        check_counts("enfall held");
        enabled_in = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (write_response_out[10]) begin
                seen = 1'b1;
                check("enfall resumed write_response", 521'(write_response_out),
                      521'({1'b1, 8'h61, C_DONE}));
            end
        end
        check("enfall resumed seen", 521'(seen), 521'(1));
        exp_wr_cnt = exp_wr_cnt + 32'd1;
        for (int c = 0; c < 4; c++) step();
        v = '{T_RD, 64'h100, 8'h62, '0, '0, K_READ_OK, C_DONE, PAT_E, PAT_F};
        run_vec(v, "enfall readback");

        // Reset asserted in the READ_H1 cycle
        drive_cmd(T_RD, 64'h80, 8'h50, '0, '0);
        step();
        idle_cmd();
        step();
        step();
        check("rst rd0 before reset", read_data_0_out, {1'b1, 8'h50, PAT_A});
        step();
        check("rst rd1 before reset", read_data_1_out, {1'b1, 8'h50, PAT_B});
        rstn = 1'b1;
        step();
        rstn = 1'b0;
        exp_rd_cnt = 32'd0;
        exp_wr_cnt = 32'd0;
        check("rst read_data_0", read_data_0_out, '0);
        check("rst read_data_1", read_data_1_out, '0);
        check("rst read_response", 521'(read_response_out), '0);
        check("rst write_response", 521'(write_response_out), '0);
        check("rst overflow_error", 521'(overflow_error), '0);
        check("rst command_buffer_full", 521'(command_buffer_full), '0);
        check_counts("rst");
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (read_response_out[10] || read_data_1_out[520]) seen = 1'b1;
            step();
        end
        check("rst no late response", 521'(seen), '0);
        v = '{T_RD, 64'h80, 8'h51, '0, '0, K_READ_OK, C_DONE, PAT_A, PAT_B};
        run_vec(v, "post reset read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cu_command_responder.md
# cu_command_responder

Memory-side responder for the compute-unit command/response protocol. It accepts read and write commands of one 128-byte cache line each (two 512-bit halves) into a command FIFO and services them in order against an internal line memory. It returns read data halves plus a read response for reads, and a write response for writes. It sits opposite the CU control/engine pair: as a synthesizable loopback target for integration, and as the reference responder in CU-level benches.

## Interface
- MEM_LINES, 64: number of 128-byte lines in the internal memory; power of two.
- FIFO_DEPTH, 8: command FIFO entries; power of two, ≥4.
- clock  in  1  single clock; all logic on its rising edge.
- rstn  in  1  reset, synchronous, active-high; it keeps the codebase port name despite its polarity.
- enabled_in  in  1  gates command acceptance and FIFO pops.
- command_valid  in  1  command present this cycle.
- command_type  in  2  00 read, 01 write, 10/11 invalid.
- command_address  in  64  byte address; bits [6:0] must be zero.
- command_tag  in  8  tag echoed on data and response.
- command_data_0_in / command_data_1_in  in  512 each  write payload halves, sampled with the command.
- command_buffer_full  out  1  asserted when FIFO occupancy ≥ FIFO_DEPTH-2.
- read_data_0_out / read_data_1_out  out  1+8+512 each  valid, tag, data.
- read_response_out / write_response_out  out  1+8+2 each  valid, tag, code (00 DONE, 01 AERROR, 10 FAILED).
- read_done_count / write_done_count  out  32 each  count of DONE responses.
- overflow_error  out  1  sticky; set when a command is dropped.

## Operation
- Accept: when command_valid && enabled_in, the full command (type, address, tag, both data halves) is pushed into the FIFO.
- If the FIFO is full when a command is offered, the command is dropped and overflow_error is set. overflow_error clears only on reset.
- When enabled_in is low, offered commands are ignored. Ignoring them is not an overflow.
- FSM states: IDLE, FETCH, READ_H0, READ_H1, READ_RSP, WRITE_RSP, ERR_RSP.
- IDLE: pops when FIFO non-empty && enabled_in, then moves to FETCH. Entries are serviced strictly in order, one at a time.
- FETCH: decodes the popped entry.
  - Invalid type: goes to ERR_RSP with code FAILED.
  - Misaligned address, or line index ≥ MEM_LINES: goes to ERR_RSP with code AERROR.
  - Valid read: drives the synchronous memory read and goes to READ_H0.
  - Valid write: writes both halves to the line and goes to WRITE_RSP.
- Line index = address[63:7]. The range check uses all upper bits, so no aliasing is allowed.
- READ_H0: drives read_data_0_out valid with half 0, then moves to READ_H1.
- READ_H1: drives read_data_1_out valid with half 1, then moves to READ_RSP.
- READ_RSP: drives read_response_out DONE and increments read_done_count, then returns to IDLE.
- WRITE_RSP: drives write_response_out DONE and increments write_done_count, then returns to IDLE.
- ERR_RSP: the error response goes on the read channel for read/invalid types and on the write channel for writes. Counters are not changed. Returns to IDLE.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- A read issued after a write to the same line returns the written data. No bypass is needed because service is serialized.
- Memory contents are not cleared by reset. Reading a line never written returns undefined data, but the response is still DONE.

## Timing
- Reset values: every valid bit 0, tags/data/codes 0, both counters 0, overflow_error 0, command_buffer_full 0, FSM in IDLE, FIFO empty.
- All outputs are registered.
- Every output valid is a one-cycle pulse. There is no back-pressure on the output channels.
- Command accepted at cycle N with the FIFO empty and the FSM idle: pop at N+1, FETCH at N+2.
  - Read: read_data_0 at N+3, read_data_1 at N+4, read_response at N+5.
  - Write: memory updated at the end of N+2, write_response at N+3.
  - Error: response at N+3.
- Back-to-back service: the next pop occurs in the cycle after the response cycle. A read therefore occupies 5 cycles and a write 3.
- Simultaneous push and pop in one cycle is legal. Occupancy is unchanged, and a push to a full FIFO during a pop is accepted.
- command_buffer_full is registered from the post-update occupancy.
- enabled_in falling mid-command: the in-flight command completes fully, then no further pops.
- rstn asserted mid-command: all in-flight and queued commands are discarded and no response is issued. Outputs take reset values on the next edge.

## Test plan
- Write tag 0x11 at address 0x80 with data halves 0xA…A/0xB…B, then read tag 0x22 at 0x80. Required: write_response DONE tag 0x11 at N+3; read_data_0 = 0xA…A and read_data_1 = 0xB…B, both tag 0x22; read_response DONE; both counters = 1.
- Read at address 0x81, and read at MEM_LINES*128. Required: each gets read_response AERROR with no read_data valid pulses; read_done_count stays 0.
- command_type 11 with tag 0x33. Required: read_response FAILED tag 0x33 at N+3.
- Push 10 back-to-back reads with FIFO_DEPTH=8 and no pops possible. Required: command_buffer_full rises after the 6th accept; overflow_error is set; exactly 8 responses with in-order tags.
- Preload write_done_count to 0xFFFFFFFF via a forced value, then do one write. Required: count wraps to 0.
- Assert rstn at the READ_H1 cycle. Required: no read_response; all outputs 0 on the next cycle; a subsequent command is serviced normally.
